// File: rtl/dna_word_packer_if.sv
// Handshake bundle between the base source, the packer and the word-sum stage.
// Digit i of word_out occupies bits [2i+1:2i].
interface dna_word_packer_if #(
    parameter int N = 4
);
    logic [1:0]     base_in;
    logic           base_valid;
    logic           base_ready;
    logic           base_last;
    logic [2*N-1:0] word_out;
    logic [6:0]     word_len;
    logic           word_valid;
    logic           word_ready;
    logic [15:0]    words_emitted;

    // master is the side feeding bases and draining words; slave is the packer
    modport master (
        output base_in, base_valid, base_last, word_ready,
        input  base_ready, word_out, word_len, word_valid, words_emitted
    );

    modport slave (
        input  base_in, base_valid, base_last, word_ready,
        output base_ready, word_out, word_len, word_valid, words_emitted
    );
endinterface

// File: rtl/dna_word_packer.sv
// Packs 2-bit DNA bases into N-digit zero-padded words with a registered
// valid/ready output; one spare word can park in the assembly register.
module dna_word_packer #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dna_word_packer_if.slave  bus
);
    typedef enum logic {FILL, HOLD} state_t;

    localparam logic [6:0] LAST_DIGIT = 7'(N - 1);

    state_t         state, state_n;
    logic [2*N-1:0] asm_q, asm_n, asm_ins;
    logic [2*N-1:0] word_q, word_n;
    logic [6:0]     cnt_q, cnt_n;
    logic [6:0]     len_q, len_n;
    logic [6:0]     hold_len_q, hold_len_n;
    logic           valid_q, valid_n;
    logic [15:0]    emitted_q, emitted_n;
    logic           ready;
    logic           accept, handoff, slot_free, complete;

    assign ready     = rst_n && (state == FILL);
    assign accept    = bus.base_valid && ready;
    assign handoff   = valid_q && bus.word_ready;
    assign slot_free = !valid_q || bus.word_ready;
    assign complete  = accept && ((cnt_q == LAST_DIGIT) || bus.base_last);

    // Current partial word with the incoming base dropped into digit cnt
    always_comb begin
        asm_ins = asm_q;
        for (int i = 0; i < N; i++) begin
            if (cnt_q == 7'(i)) begin
                asm_ins[2*i +: 2] = bus.base_in;
            end
        end
    end

    always_comb begin
        state_n    = state;
        asm_n      = asm_q;
        cnt_n      = cnt_q;
        word_n     = word_q;
        len_n      = len_q;
        hold_len_n = hold_len_q;
        valid_n    = valid_q && !bus.word_ready;
        emitted_n  = handoff ? 16'(emitted_q + 16'd1) : emitted_q;

        unique case (state)
            FILL: begin
                if (complete && slot_free) begin
                    word_n  = asm_ins;
                    len_n   = 7'(cnt_q + 7'd1);
                    valid_n = 1'b1;
                    asm_n   = '0;
                    cnt_n   = '0;
                end else if (complete) begin
                    asm_n      = asm_ins;
                    hold_len_n = 7'(cnt_q + 7'd1);
                    state_n    = HOLD;
                end else if (accept) begin
                    asm_n = asm_ins;
                    cnt_n = 7'(cnt_q + 7'd1);
                end
            end
            HOLD: begin
                if (slot_free) begin
                    word_n  = asm_q;
                    len_n   = hold_len_q;
                    valid_n = 1'b1;
                    asm_n   = '0;
                    cnt_n   = '0;
                    state_n = FILL;
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL;
            asm_q      <= '0;
            cnt_q      <= '0;
            word_q     <= '0;
            len_q      <= '0;
            hold_len_q <= '0;
            valid_q    <= 1'b0;
            emitted_q  <= '0;
        end else begin
            state      <= state_n;
            asm_q      <= asm_n;
            cnt_q      <= cnt_n;
            word_q     <= word_n;
            len_q      <= len_n;
            hold_len_q <= hold_len_n;
            valid_q    <= valid_n;
            emitted_q  <= emitted_n;
        end
    end

    assign bus.base_ready    = ready;
    assign bus.word_out      = word_q;
    assign bus.word_len      = len_q;
    assign bus.word_valid    = valid_q;
    assign bus.words_emitted = emitted_q;
endmodule

// File: tb/tb_dna_word_packer.sv
// Directed bench for dna_word_packer: an N=4 instance for packing, flush,
// back-pressure and reset, and an N=1 instance for streaming and counter wrap.
module tb_dna_word_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    dna_word_packer_if #(.N(4)) bus4 ();
    dna_word_packer_if #(.N(1)) bus1 ();

    dna_word_packer #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    dna_word_packer #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one base to the N=4 packer for a single edge
    task automatic applyStimulus(input logic [1:0] b, input logic last);
        bus4.base_in    = b;
        bus4.base_valid = 1'b1;
        bus4.base_last  = last;
        step();
        bus4.base_valid = 1'b0;
        bus4.base_last  = 1'b0;
    endtask

    task automatic checkWord4(input string tag, input logic [7:0] w, input logic [6:0] len);
        checkOutput({tag, "_valid"}, 16'(bus4.word_valid), 16'd1);
        checkOutput({tag, "_word"},  16'(bus4.word_out), 16'(w));
        checkOutput({tag, "_len"},   16'(bus4.word_len), 16'(len));
    endtask

    int ready_drops;

    initial begin
        bus4.base_in = '0; bus4.base_valid = 1'b0; bus4.base_last = 1'b0; bus4.word_ready = 1'b1;
        bus1.base_in = '0; bus1.base_valid = 1'b0; bus1.base_last = 1'b0; bus1.word_ready = 1'b1;

        // reset state
        step(); step();
        checkOutput("rst_ready", 16'(bus4.base_ready), 16'd0);
        checkOutput("rst_valid", 16'(bus4.word_valid), 16'd0);
        checkOutput("rst_word", 16'(bus4.word_out), 16'd0);
        checkOutput("rst_len", 16'(bus4.word_len), 16'd0);
        checkOutput("rst_emitted", bus4.words_emitted, 16'd0);
        rst_n = 1'b1;
        step();
        checkOutput("rel_ready", 16'(bus4.base_ready), 16'd1);

        // basic packing 1,2,3,0 -> 0x39
        applyStimulus(2'd1, 1'b0);
        applyStimulus(2'd2, 1'b0);
        applyStimulus(2'd3, 1'b0);
        checkOutput("basic_notyet", 16'(bus4.word_valid), 16'd0);
        applyStimulus(2'd0, 1'b0);
        checkWord4("basic", 8'h39, 7'd4);
        step();
        checkOutput("basic_drop", 16'(bus4.word_valid), 16'd0);
        checkOutput("basic_emitted", bus4.words_emitted, 16'd1);

        // partial flush 3,3(last) -> 0x0F len 2, then 2,1(last) -> 0x06 len 2
        applyStimulus(2'd3, 1'b0);
        applyStimulus(2'd3, 1'b1);
        checkWord4("flush", 8'h0F, 7'd2);
        applyStimulus(2'd2, 1'b0);
        applyStimulus(2'd1, 1'b1);
        checkWord4("flush_next", 8'h06, 7'd2);
        step();
        checkOutput("flush_emitted", bus4.words_emitted, 16'd3);

        // back-pressure: twelve 2s with word_ready low
        bus4.word_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("bp_ready_on", 16'(bus4.base_ready), 16'd1);
            applyStimulus(2'd2, 1'b0);
        end
        checkOutput("bp_ready_off", 16'(bus4.base_ready), 16'd0);
        checkWord4("bp_first", 8'hAA, 7'd4);
        bus4.base_in = 2'd2; bus4.base_valid = 1'b1;
        step();
        checkOutput("bp_still_off", 16'(bus4.base_ready), 16'd0);
        checkWord4("bp_stable", 8'hAA, 7'd4);
        bus4.word_ready = 1'b1;
        step();
        bus4.word_ready = 1'b0;
        checkOutput("bp_ready_back", 16'(bus4.base_ready), 16'd1);
        checkWord4("bp_second", 8'hAA, 7'd4);
        checkOutput("bp_emitted1", bus4.words_emitted, 16'd4);
        for (int i = 0; i < 4; i++) applyStimulus(2'd2, 1'b0);
        checkOutput("bp_hold2", 16'(bus4.base_ready), 16'd0);
        bus4.word_ready = 1'b1;
        step();
        checkWord4("bp_third", 8'hAA, 7'd4);
        checkOutput("bp_emitted2", bus4.words_emitted, 16'd5);
        step();
        checkOutput("bp_done_valid", 16'(bus4.word_valid), 16'd0);
        checkOutput("bp_emitted3", bus4.words_emitted, 16'd6);

        // reset after two bases of a word
        applyStimulus(2'd3, 1'b0);
        applyStimulus(2'd3, 1'b0);
        rst_n = 1'b0;
        step();
        checkOutput("rstmid_ready", 16'(bus4.base_ready), 16'd0);
        checkOutput("rstmid_emitted", bus4.words_emitted, 16'd0);
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 4; i++) applyStimulus(2'd1, 1'b0);
        checkWord4("rstmid_fresh", 8'h55, 7'd4);
        step();
        checkOutput("rstmid_emitted2", bus4.words_emitted, 16'd1);

        // reset while in HOLD
        bus4.word_ready = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(2'd3, 1'b0);
        checkOutput("rsthold_inhold", 16'(bus4.base_ready), 16'd0);
        rst_n = 1'b0;
        step();
        checkOutput("rsthold_valid", 16'(bus4.word_valid), 16'd0);
        checkOutput("rsthold_word", 16'(bus4.word_out), 16'd0);
        checkOutput("rsthold_len", 16'(bus4.word_len), 16'd0);
        rst_n = 1'b1;
        bus4.word_ready = 1'b1;
        step();
        applyStimulus(2'd0, 1'b0);
        applyStimulus(2'd1, 1'b0);
        applyStimulus(2'd2, 1'b0);
        applyStimulus(2'd3, 1'b0);
        checkWord4("rsthold_fresh", 8'hE4, 7'd4);
        step();
        checkOutput("rsthold_emitted", bus4.words_emitted, 16'd1);

        // N=1 streaming: one word per cycle, ready never drops
        ready_drops = 0;
        bus1.base_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            bus1.base_in = 2'(i);
            if (bus1.base_ready !== 1'b1) ready_drops++;
            step();
            if (i < 4) begin
                checkOutput("n1_valid", 16'(bus1.word_valid), 16'd1);
                checkOutput("n1_word", 16'(bus1.word_out), 16'(i % 4));
                checkOutput("n1_len", 16'(bus1.word_len), 16'd1);
            end
        end
        bus1.base_valid = 1'b0;
        checkOutput("n1_ready_drops", 16'(ready_drops), 16'd0);
        step();
        checkOutput("wrap_ffff", bus1.words_emitted, 16'hFFFF);
        bus1.base_in = 2'd2; bus1.base_valid = 1'b1;
        step();
        bus1.base_valid = 1'b0;
        step();
        checkOutput("wrap_zero", bus1.words_emitted, 16'h0000);
        bus1.base_valid = 1'b1;
        step();
        bus1.base_valid = 1'b0;
        step();
        checkOutput("wrap_one", bus1.words_emitted, 16'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
